// File: rtl/fpu_pkg.sv
// Shared floating-point types, constants and helpers for the FPU datapaths.
package fpu_pkg;

    typedef enum logic { RM_RNE = 1'b0, RM_RTZ = 1'b1 } rm_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fflags_t;

    typedef enum logic [2:0] { ZERO, NORM, INF, QNAN, SNAN } class_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int frac_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << frac_w;
        r = r | (64'd1 << (frac_w - 1));
        return r;
    endfunction

    // Denormals (exponent zero) classify as ZERO so they are flushed.
    function automatic class_t fp_classify(input logic exp_ones, input logic exp_zero,
                                           input logic frac_zero, input logic frac_msb);
        class_t c;
        if (exp_zero)       c = ZERO;
        else if (!exp_ones) c = NORM;
        else if (frac_zero) c = INF;
        else if (frac_msb)  c = QNAN;
        else                c = SNAN;
        return c;
    endfunction

endpackage

// File: rtl/fmul_round_pack.sv
// Rounds a normalised mantissa with guard/round/sticky, applies flush-to-zero
// underflow and overflow-to-infinity, and packs the IEEE result.
module fmul_round_pack
    import fpu_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    sign,
    input  logic signed [EXP_W+1:0] exp_in,
    input  logic [FRAC_W:0]         mant,
    input  logic                    guard,
    input  logic                    round_bit,
    input  logic                    sticky,
    input  rm_t                     rm,
    output logic [EXP_W+FRAC_W:0]   y,
    output fflags_t                 flags
);
    localparam logic signed [EXP_W+1:0] EXP_MAX  = (EXP_W+2)'((1 << EXP_W) - 1);
    localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;
    localparam logic signed [EXP_W+1:0] EXP_ONE  = (EXP_W+2)'(1);

    logic                    round_up;
    logic [FRAC_W+1:0]       mant_r;
    logic signed [EXP_W+1:0] exp_r;
    logic [FRAC_W-1:0]       frac_r;

    always_comb begin
        round_up = (rm == RM_RNE) && guard && (round_bit || sticky || mant[0]);
        mant_r   = {1'b0, mant} + {{(FRAC_W+1){1'b0}}, round_up};
        exp_r    = exp_in;
        frac_r   = mant_r[FRAC_W-1:0];
        // A rounding carry yields 10.00..0; shift right once and bump the exponent.
        if (mant_r[FRAC_W+1]) begin
            exp_r  = exp_in + EXP_ONE;
            frac_r = mant_r[FRAC_W:1];
        end
        flags         = '0;
        flags.inexact = guard | round_bit | sticky;
        y             = {sign, exp_r[EXP_W-1:0], frac_r};
        if (exp_r >= EXP_MAX) begin
            y              = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            flags.overflow = 1'b1;
            flags.inexact  = 1'b1;
        end else if (exp_r <= EXP_ZERO) begin
            y               = {sign, {(EXP_W+FRAC_W){1'b0}}};
            flags.underflow = 1'b1;
            flags.inexact   = 1'b1;
        end
    end

endmodule

// File: rtl/fmul_pipe.sv
// Pipelined floating-point multiplier with valid/ready handshake, RNE/RTZ
// rounding, IEEE special values and exception flags; latency is STAGES cycles.
module fmul_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+FRAC_W:0] x1,
    input  logic [EXP_W+FRAC_W:0] x2,
    input  logic                  rm,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+FRAC_W:0] y,
    output logic [TAG_W-1:0]      out_tag,
    output logic [3:0]            flags
);
    localparam int W = 1 + EXP_W + FRAC_W;
    localparam int M = FRAC_W + 1;
    localparam int H = M / 2;
    localparam int P = 2 * M;
    localparam logic [63:0]      QNAN64  = fp_qnan(EXP_W, FRAC_W);
    localparam logic [W-1:0]     QNAN_Y  = QNAN64[W-1:0];
    localparam logic [EXP_W+1:0] BIAS_X  = (EXP_W+2)'(fp_bias(EXP_W));
    localparam logic [EXP_W+1:0] EXP_ONE = (EXP_W+2)'(1);

    typedef struct packed {
        logic             sign;
        logic [EXP_W+1:0] exp;
        logic [M+H-1:0]   pp_lo;
        logic [2*M-H-1:0] pp_hi;
        logic             special;
        logic [W-1:0]     spec_y;
        fflags_t          spec_flags;
        rm_t              rm;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W+1:0] exp;
        logic [P-1:0]     prod;
        logic             special;
        logic [W-1:0]     spec_y;
        fflags_t          spec_flags;
        rm_t              rm;
        logic [TAG_W-1:0] tag;
    } prod_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W+1:0] exp;
        logic [M-1:0]     mant;
        logic             guard;
        logic             round_bit;
        logic             sticky;
        logic             special;
        logic [W-1:0]     spec_y;
        fflags_t          spec_flags;
        rm_t              rm;
        logic [TAG_W-1:0] tag;
    } norm_t;

    function automatic prod_t f_sum(input s1_t s);
        prod_t r;
        r.sign       = s.sign;
        r.exp        = s.exp;
        r.prod       = {{(M-H){1'b0}}, s.pp_lo} + {s.pp_hi, {H{1'b0}}};
        r.special    = s.special;
        r.spec_y     = s.spec_y;
        r.spec_flags = s.spec_flags;
        r.rm         = s.rm;
        r.tag        = s.tag;
        return r;
    endfunction

    // Product of two [1,2) mantissas lies in [1,4); the top bit selects a 1-bit shift.
    function automatic norm_t f_norm(input prod_t p);
        norm_t n;
        n.sign       = p.sign;
        n.special    = p.special;
        n.spec_y     = p.spec_y;
        n.spec_flags = p.spec_flags;
        n.rm         = p.rm;
        n.tag        = p.tag;
        if (p.prod[P-1]) begin
            n.exp       = p.exp + EXP_ONE;
            n.mant      = p.prod[P-1:M];
            n.guard     = p.prod[M-1];
            n.round_bit = p.prod[M-2];
            n.sticky    = |p.prod[M-3:0];
        end else begin
            n.exp       = p.exp;
            n.mant      = p.prod[P-2:M-1];
            n.guard     = p.prod[M-2];
            n.round_bit = p.prod[M-3];
            n.sticky    = |p.prod[M-4:0];
        end
        return n;
    endfunction

    logic              advance;
    logic [STAGES-1:0] vld_q, vld_d;
    s1_t               s1_q, s1_d, s1_n;
    norm_t             rp_src;
    logic [W-1:0]      rp_y;
    fflags_t           rp_flags;
    logic [W-1:0]      y_q, y_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    fflags_t           flags_q, flags_d;

    logic [EXP_W-1:0]  e1, e2;
    logic [FRAC_W-1:0] f1, f2;
    logic [M-1:0]      ma, mb;
    class_t            c1, c2;
    logic              any_nan, inf_zero;

    assign out_valid = vld_q[STAGES-1];
    assign in_ready  = !out_valid || out_ready;
    assign advance   = in_ready;

    always_comb begin
        vld_d = vld_q;
        if (advance) vld_d = {vld_q[STAGES-2:0], in_valid};
    end

    always_comb begin
        e1       = x1[W-2:FRAC_W];
        e2       = x2[W-2:FRAC_W];
        f1       = x1[FRAC_W-1:0];
        f2       = x2[FRAC_W-1:0];
        ma       = {1'b1, f1};
        mb       = {1'b1, f2};
        c1       = fp_classify(&e1, ~|e1, ~|f1, f1[FRAC_W-1]);
        c2       = fp_classify(&e2, ~|e2, ~|f2, f2[FRAC_W-1]);
        any_nan  = (c1 == QNAN) || (c1 == SNAN) || (c2 == QNAN) || (c2 == SNAN);
        inf_zero = ((c1 == INF) && (c2 == ZERO)) || ((c1 == ZERO) && (c2 == INF));

        s1_n       = '0;
        s1_n.sign  = x1[W-1] ^ x2[W-1];
        s1_n.exp   = {2'b00, e1} + {2'b00, e2} - BIAS_X;
        s1_n.pp_lo = {{H{1'b0}}, ma} * {{M{1'b0}}, mb[H-1:0]};
        s1_n.pp_hi = {{(M-H){1'b0}}, ma} * {{M{1'b0}}, mb[M-1:H]};
        s1_n.rm    = rm_t'(rm);
        s1_n.tag   = in_tag;
        s1_n.special = 1'b1;
        if (any_nan || inf_zero) begin
            s1_n.spec_y             = QNAN_Y;
            s1_n.spec_flags.invalid = inf_zero || (c1 == SNAN) || (c2 == SNAN);
        end else if ((c1 == INF) || (c2 == INF)) begin
            s1_n.spec_y = {s1_n.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if ((c1 == ZERO) || (c2 == ZERO)) begin
            s1_n.spec_y = {s1_n.sign, {(EXP_W+FRAC_W){1'b0}}};
        end else begin
            s1_n.special = 1'b0;
        end

        s1_d = advance ? s1_n : s1_q;
    end

    generate
        if (STAGES == 2) begin : g_st2
            assign rp_src = f_norm(f_sum(s1_q));
        end else if (STAGES == 3) begin : g_st3
            norm_t s2_q, s2_d;
            always_comb s2_d = advance ? f_norm(f_sum(s1_q)) : s2_q;
            always_ff @(posedge clk) begin
                if (rst) s2_q <= '0;
                else     s2_q <= s2_d;
            end
            assign rp_src = s2_q;
        end else begin : g_st4
            prod_t s2_q, s2_d;
            norm_t s3_q, s3_d;
            always_comb begin
                s2_d = advance ? f_sum(s1_q) : s2_q;
                s3_d = advance ? f_norm(s2_q) : s3_q;
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_q <= '0;
                    s3_q <= '0;
                end else begin
                    s2_q <= s2_d;
                    s3_q <= s3_d;
                end
            end
            assign rp_src = s3_q;
        end
    endgenerate

    fmul_round_pack #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_round_pack (
        .sign      (rp_src.sign),
        .exp_in    (rp_src.exp),
        .mant      (rp_src.mant),
        .guard     (rp_src.guard),
        .round_bit (rp_src.round_bit),
        .sticky    (rp_src.sticky),
        .rm        (rp_src.rm),
        .y         (rp_y),
        .flags     (rp_flags)
    );

    always_comb begin
        y_d     = y_q;
        tag_d   = tag_q;
        flags_d = flags_q;
        if (advance) begin
            y_d     = rp_src.special ? rp_src.spec_y : rp_y;
            flags_d = rp_src.special ? rp_src.spec_flags : rp_flags;
            tag_d   = rp_src.tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            s1_q    <= '0;
            y_q     <= '0;
            tag_q   <= '0;
            flags_q <= '0;
        end else begin
            vld_q   <= vld_d;
            s1_q    <= s1_d;
            y_q     <= y_d;
            tag_q   <= tag_d;
            flags_q <= flags_d;
        end
    end

    assign y       = y_q;
    assign out_tag = tag_q;
    assign flags   = flags_q;

endmodule
